// File: rtl/monitor_bus_master.sv
// Bus master that runs one address/data transaction per host command on the
// card's strobed 8-bit bus, plus a synchronized interrupt input.

// state       | meaning
// IDLE        | waiting for a command; cmd_ready high, bus released
// ADDR_SETUP  | slot selected, address driven, strobe high
// ADDR_STROBE | address driven, strobe low
// ADDR_HOLD   | address driven, strobe high
// DATA_SETUP  | write data driven (or bus turned around for a read)
// DATA_STROBE | strobe low; a read samples ad_in on its last cycle
// DATA_HOLD   | strobe high, slot still selected
// DONE        | one-cycle rsp_valid, bus released
module monitor_bus_master #(
    parameter int unsigned PHASE_LEN = 8
) (
    input  logic       clk_50mhz_in,
    input  logic       reset_x,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       slot_x_int_x,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic [7:0] ad,
    output logic       ad_oe_x,
    input  logic [7:0] ad_in,
    input  logic       irq_x,
    output logic       irq_pending,
    output logic       irq_event
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        DATA_SETUP,
        DATA_STROBE,
        DATA_HOLD,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(PHASE_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       slot_q, slot_d;
    logic       clk_rw_q, clk_rw_d;
    logic       ax_d_q, ax_d_d;
    logic       r_wx_q, r_wx_d;
    logic [7:0] ad_q, ad_d;
    logic       ad_oe_x_q, ad_oe_x_d;

    logic       irq_s1_q, irq_s2_q;
    logic       irq_event_q, irq_event_d;

    logic       addr_ph, data_ph, strobe_ph;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (cmd_valid && cmd_ready_q) begin
                    state_d = ADDR_SETUP;
                    cnt_d   = RELOAD;
                    wr_d    = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = RELOAD;
                    case (state_q)
                        ADDR_SETUP:  state_d = ADDR_STROBE;
                        ADDR_STROBE: state_d = ADDR_HOLD;
                        ADDR_HOLD:   state_d = DATA_SETUP;
                        DATA_SETUP:  state_d = DATA_STROBE;
                        DATA_STROBE: state_d = DATA_HOLD;
                        default: begin
                            state_d = DONE;
                            cnt_d   = 8'd0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase

        // card data is only guaranteed stable at the end of the data strobe
        if (state_q == DATA_STROBE && cnt_q == 8'd0 && !wr_q) begin
            rsp_rdata_d = ad_in;
        end

        // bus outputs are decoded from the next state so they leave flops
        addr_ph   = (state_d == ADDR_SETUP) || (state_d == ADDR_STROBE) ||
                    (state_d == ADDR_HOLD);
        data_ph   = (state_d == DATA_SETUP) || (state_d == DATA_STROBE) ||
                    (state_d == DATA_HOLD);
        strobe_ph = (state_d == ADDR_STROBE) || (state_d == DATA_STROBE);

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        slot_d      = !(addr_ph || data_ph);
        clk_rw_d    = !strobe_ph;
        ax_d_d      = !data_ph;
        r_wx_d      = (addr_ph || data_ph) ? !wr_d : 1'b1;
        ad_oe_x_d   = !(addr_ph || (data_ph && wr_d));

        ad_d = ad_q;
        if (addr_ph) begin
            ad_d = addr_d;
        end else if (data_ph && wr_d) begin
            ad_d = wdata_d;
        end

        irq_event_d = irq_s2_q && !irq_s1_q;
    end

    always_ff @(posedge clk_50mhz_in) begin
        if (!reset_x) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            slot_q      <= 1'b1;
            clk_rw_q    <= 1'b1;
            ax_d_q      <= 1'b1;
            r_wx_q      <= 1'b1;
            ad_q        <= 8'd0;
            ad_oe_x_q   <= 1'b1;
            irq_s1_q    <= 1'b1;
            irq_s2_q    <= 1'b1;
            irq_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            slot_q      <= slot_d;
            clk_rw_q    <= clk_rw_d;
            ax_d_q      <= ax_d_d;
            r_wx_q      <= r_wx_d;
            ad_q        <= ad_d;
            ad_oe_x_q   <= ad_oe_x_d;
            irq_s1_q    <= irq_x;
            irq_s2_q    <= irq_s1_q;
            irq_event_q <= irq_event_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign slot_x_int_x = slot_q;
    assign clk_rw       = clk_rw_q;
    assign ax_d         = ax_d_q;
    assign r_wx         = r_wx_q;
    assign ad           = ad_q;
    assign ad_oe_x      = ad_oe_x_q;
    assign irq_pending  = !irq_s2_q;
    assign irq_event    = irq_event_q;

endmodule
